exhaustive_vector_sweeper: RTL and testbench

- Sequential stimulus and response stage for small combinational blocks under test, such as the 4-input task blocks.
- Drives all 2^WIDTH input vectors in ascending binary order and holds each vector for HOLD clock cycles.
- Samples the DUT's single-bit output once per vector and assembles the full truth table plus a count of ones.
- Replaces hand-written per-vector sequences with a start/busy/done-controlled block usable in benches and on the board.

---
 rtl/exhaustive_vector_sweeper.sv | 82 ++++++++
 tb/tb_exhaustive_vector_sweeper.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_sweeper.sv
// Exhaustive stimulus/response sweeper for small combinational blocks.
// Drives every WIDTH-bit vector in ascending order. Each vector is held for HOLD cycles.
// The single-bit response is sampled on the last cycle of each hold into a truth table,
// and the ones in that table are counted.
module exhaustive_vector_sweeper #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [WIDTH-1:0]      pattern,
  input  logic                  y_in,
  output logic                  busy,
  output logic                  done,
  output logic [2**WIDTH-1:0]   truth,
  output logic [WIDTH:0]        ones_cnt
);

  localparam int unsigned HW = $clog2(HOLD);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StFinish
  } state_e;

  state_e          state_q;
  logic [HW-1:0]   hold_q;

  // Sweep sequencer: steps the vectors, times each hold and records the sampled response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pattern  <= '0;
      hold_q   <= '0;
      truth    <= '0;
      ones_cnt <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StDrive;
            pattern  <= '0;
            hold_q   <= '0;
            truth    <= '0;
            ones_cnt <= '0;
          end
        end
        StDrive: begin
          if (hold_q == HoldLast) begin
            truth[pattern] <= y_in;
            ones_cnt       <= ones_cnt + {{WIDTH{1'b0}}, y_in};
            // The terminal vector ends the sweep, so pattern never wraps.
            if (pattern == {WIDTH{1'b1}}) begin
              state_q <= StFinish;
            end else begin
              pattern <= pattern + WIDTH'(1);
              hold_q  <= '0;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status flags decoded straight from the state register; start has no path to them.
  always_comb begin
    busy = (state_q == StDrive);
    done = (state_q == StFinish);
  end

endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// Bench for exhaustive_vector_sweeper.
// A timeline model, expressed in edges counted since the accepting edge, is compared
// against the DUT on every negedge. Directed sweeps are pinned with literal results.
module tb_exhaustive_vector_sweeper;

  localparam int W  = 4;
  localparam int H  = 10;
  localparam int N  = 16;
  localparam int SW = N * H;

  localparam logic [1:0] ModeXor  = 2'd0;
  localparam logic [1:0] ModeAnd  = 2'd1;
  localparam logic [1:0] ModeZero = 2'd2;
  localparam logic [1:0] ModeRand = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          y_rand;
  logic          y_in;
  logic [W-1:0]  pattern;
  logic          busy;
  logic          done;
  logic [N-1:0]  truth;
  logic [W:0]    ones_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exhaustive_vector_sweeper #(.WIDTH(W), .HOLD(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .y_in     (y_in),
    .busy     (busy),
    .done     (done),
    .truth    (truth),
    .ones_cnt (ones_cnt)
  );

  // Stand-in combinational block under test.
  function automatic logic fy(input logic [1:0] m, input logic [W-1:0] v, input logic r);
    case (m)
      ModeXor: fy = ^v;
      ModeAnd: fy = &v;
      ModeZero: fy = 1'b0;
      default: fy = r;
    endcase
  endfunction

  assign y_in = fy(mode, pattern, y_rand);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after the k-th edge since acceptance, vector k/H is applied.
  // Vector j has been sampled once (j+1)*H <= k. done is high after edge SW, and the
  // block is idle again after edge SW+1.
  bit            m_active = 1'b0;
  bit            chk_en   = 1'b0;
  int            m_k      = 0;
  logic [W-1:0]  e_pat;
  logic          e_busy;
  logic          e_done;
  logic [N-1:0]  e_truth;
  logic [W:0]    e_ones;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      chk_en   = 1'b1;
      e_pat    = '0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_truth  = '0;
      e_ones   = '0;
    end else begin
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_k      = 0;
        end
      end else begin
        m_k++;
      end
      if (m_active) begin
        e_busy  = (m_k < SW);
        e_done  = (m_k == SW);
        e_pat   = (m_k < SW) ? W'(m_k / H) : W'(N - 1);
        e_truth = '0;
        e_ones  = '0;
        for (int j = 0; j < N; j++) begin
          if ((j + 1) * H <= m_k) begin
            e_truth[j] = fy(mode, W'(j), 1'b0);
            e_ones     = e_ones + (W + 1)'(e_truth[j]);
          end
        end
        if (m_k == SW + 1) m_active = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pattern", 32'(pattern), 32'(e_pat));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("truth", 32'(truth), 32'(e_truth));
      chk("ones_cnt", 32'(ones_cnt), 32'(e_ones));
    end
  end

  // Accept a sweep, then watch it.
  // done_at is the index of the cycle after acceptance in which done was seen.
  task automatic run_sweep(input logic [1:0] m, input bit repulse, output int done_at,
                           output int busy_n);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    done_at = -1;
    busy_n  = 0;
    for (int i = 0; i < 400 && done_at < 0; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) busy_n++;
      if (done) done_at = i;
      start = repulse && (i == 5 || i == 80);
    end
    start = 1'b0;
  endtask

  int d_at;
  int b_n;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mode   = ModeRand;
    y_rand = 1'b0;

    // Reset held for three edges with random start and y_in.
    repeat (3) begin
      @(negedge clk);
      start  = 1'($urandom);
      y_rand = 1'($urandom);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_pattern", 32'(pattern), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_truth", 32'(truth), 32'h0000);
    chk("rst_ones", 32'(ones_cnt), 32'd0);

    // XOR sweep.
    run_sweep(ModeXor, 1'b0, d_at, b_n);
    chk("xor_done_at", 32'(d_at), 32'(SW));
    chk("xor_busy_cycles", 32'(b_n), 32'(SW));
    chk("xor_truth", 32'(truth), 32'h6996);
    chk("xor_ones", 32'(ones_cnt), 32'd8);
    @(negedge clk);
    chk("idle_hold_truth", 32'(truth), 32'h6996);
    chk("idle_hold_pattern", 32'(pattern), 32'hf);

    // AND sweep and constant-0 sweep.
    run_sweep(ModeAnd, 1'b0, d_at, b_n);
    chk("and_truth", 32'(truth), 32'h8000);
    chk("and_ones", 32'(ones_cnt), 32'd1);
    run_sweep(ModeZero, 1'b0, d_at, b_n);
    chk("zero_truth", 32'(truth), 32'h0000);
    chk("zero_ones", 32'(ones_cnt), 32'd0);

    // start re-pulsed mid-sweep must be ignored.
    run_sweep(ModeXor, 1'b1, d_at, b_n);
    chk("repulse_done_at", 32'(d_at), 32'(SW));
    chk("repulse_busy_cycles", 32'(b_n), 32'(SW));
    chk("repulse_truth", 32'(truth), 32'h6996);
    chk("repulse_ones", 32'(ones_cnt), 32'd8);

    // Reset during the hold of vector 5 aborts the sweep.
    @(negedge clk);
    mode  = ModeXor;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (55) @(negedge clk);
    chk("mid_pattern_before_rst", 32'(pattern), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_pattern", 32'(pattern), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_truth", 32'(truth), 32'h0000);
    chk("abort_ones", 32'(ones_cnt), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    run_sweep(ModeXor, 1'b0, d_at, b_n);
    chk("after_abort_truth", 32'(truth), 32'h6996);
    chk("after_abort_done_at", 32'(d_at), 32'(SW));

    // start held high: one idle cycle after done, then an automatic re-arm.
    @(negedge clk);
    mode  = ModeXor;
    start = 1'b1;
    d_at  = -1;
    for (int i = 0; i < 400 && d_at < 0; i++) begin
      @(negedge clk);
      if (done) d_at = i;
    end
    chk("b2b_done_at", 32'(d_at), 32'(SW));
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_done", 32'(done), 32'd0);
    chk("b2b_idle_truth", 32'(truth), 32'h6996);
    @(negedge clk);
    chk("b2b_rearm_busy", 32'(busy), 32'd1);
    chk("b2b_rearm_truth", 32'(truth), 32'h0000);
    chk("b2b_rearm_ones", 32'(ones_cnt), 32'd0);
    chk("b2b_rearm_pattern", 32'(pattern), 32'd0);
    start = 1'b0;
    d_at  = -1;
    for (int i = 0; i < 400 && d_at < 0; i++) begin
      @(negedge clk);
      if (done) d_at = i;
    end
    chk("b2b_second_done_seen", 32'(d_at >= 0), 32'd1);
    chk("b2b_second_truth", 32'(truth), 32'h6996);
    chk("b2b_second_ones", 32'(ones_cnt), 32'd8);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
